// File: rtl/axis_host_pkt_src_pkg.sv
// Shared types and pattern helpers for the host stream packet source.
// The lane and keep helpers are the single definition of the traffic
// pattern, so a sink-side checker can import them and agree bit-for-bit.
package axis_host_pkt_src_pkg;

    localparam int DEF_DATA_BITS = 512;
    localparam int DEF_ID_BITS   = 6;
    localparam int DEF_LEN_BITS  = 28;
    localparam int BEAT_BYTES    = DEF_DATA_BITS / 8;
    localparam int BEAT_LANES    = DEF_DATA_BITS / 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } gen_state_t;

    // Value of one 32-bit lane: seed + beat*lanes + lane, wrapping at 2^32.
    function automatic logic [31:0] pattern_lane(input logic [31:0] seed,
                                                 input logic [31:0] beat_idx,
                                                 input logic [31:0] lanes,
                                                 input logic [31:0] lane);
        return seed + (beat_idx * lanes) + lane;
    endfunction

    // Byte enable for one byte of the final beat; rem==0 means a full beat.
    function automatic logic keep_bit(input logic [31:0] rem,
                                      input logic [31:0] byte_idx);
        return (rem == 32'd0) || (byte_idx < rem);
    endfunction

    // Whole beat word for the default bus width.
    function automatic logic [DEF_DATA_BITS-1:0] beat_pattern(input logic [31:0] seed,
                                                              input logic [31:0] beat_idx);
        logic [DEF_DATA_BITS-1:0] word;
        word = '0;
        for (int k = 0; k < BEAT_LANES; k++) begin
            word[k*32 +: 32] = pattern_lane(seed, beat_idx, 32'(BEAT_LANES), 32'(k));
        end
        return word;
    endfunction

    // Keep mask of the final beat of a packet of len bytes, default bus width.
    function automatic logic [BEAT_BYTES-1:0] last_keep(input logic [31:0] len);
        logic [BEAT_BYTES-1:0] keep;
        logic [31:0]           rem;
        rem  = len % 32'(BEAT_BYTES);
        keep = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep[i] = keep_bit(rem, 32'(i));
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_host_pkt_src_if.sv
// AXI4-Stream bundle between the packet source and a user-logic sink.
interface axis_host_pkt_src_if
    import axis_host_pkt_src_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ID_BITS   = DEF_ID_BITS
);

    logic                   tvalid;
    logic                   tready;
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [ID_BITS-1:0]     tid;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tid,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tid,
        output tready
    );

endinterface

// File: rtl/axis_host_pkt_src_pattern_beat.sv
// Combinational beat generator: data lanes and keep mask for one beat index.
// Kept separate so the matching sink-side checker can reuse it unchanged.
module axis_host_pkt_src_pattern_beat
    import axis_host_pkt_src_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS
)
(
    input  logic [31:0]            seed,
    input  logic [LEN_BITS-1:0]    beat_idx,
    input  logic [LEN_BITS-1:0]    len,
    input  logic                   is_last,
    output logic [DATA_BITS-1:0]   data,
    output logic [DATA_BITS/8-1:0] keep
);

    localparam int LANES          = DATA_BITS / 32;
    localparam int BYTES_PER_BEAT = DATA_BITS / 8;

    logic [31:0] rem;

    // Build every lane from the shared helper; only the final beat can be partial.
    always_comb begin
        rem  = 32'(len) % 32'(BYTES_PER_BEAT);
        data = '0;
        keep = '0;
        for (int k = 0; k < LANES; k++) begin
            data[k*32 +: 32] = pattern_lane(seed, 32'(beat_idx), 32'(LANES), 32'(k));
        end
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            keep[i] = !is_last || keep_bit(rem, 32'(i));
        end
    end

endmodule

// File: rtl/axis_host_pkt_src.sv
// Host stream packet source: turns a (length, id, seed) command into one
// AXI4-Stream packet of deterministic pattern beats. Every output is a
// register, so tvalid never depends combinationally on tready.
module axis_host_pkt_src
    import axis_host_pkt_src_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ID_BITS   = DEF_ID_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS
)
(
    input  logic                aclk,
    input  logic                aresetn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic [ID_BITS-1:0]  cmd_id,
    input  logic [31:0]         cmd_seed,

    axis_host_pkt_src_if.master m_axis,

    output logic                busy,
    output logic [31:0]         pkt_cnt,
    output logic [31:0]         beat_cnt
);

    localparam int KEEP_BITS      = DATA_BITS / 8;
    localparam int BYTES_PER_BEAT = DATA_BITS / 8;
    localparam logic [LEN_BITS-1:0] BPB_LEN = LEN_BITS'(BYTES_PER_BEAT);
    localparam logic [LEN_BITS-1:0] ONE_LEN = LEN_BITS'(1);

    gen_state_t             state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [DATA_BITS-1:0]   tdata_q, tdata_d;
    logic [KEEP_BITS-1:0]   tkeep_q, tkeep_d;
    logic [ID_BITS-1:0]     tid_q, tid_d;
    logic [31:0]            seed_q, seed_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [LEN_BITS-1:0]    last_idx_q, last_idx_d;
    logic [LEN_BITS-1:0]    beat_q, beat_d;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;
    logic [31:0]            beat_cnt_q, beat_cnt_d;

    logic [LEN_BITS-1:0]    cmd_last_idx;
    logic [31:0]            pat_seed;
    logic [LEN_BITS-1:0]    pat_idx;
    logic [LEN_BITS-1:0]    pat_len;
    logic                   pat_last;
    logic [DATA_BITS-1:0]   pat_data;
    logic [KEEP_BITS-1:0]   pat_keep;
    logic                   handshake;

    // Pick which beat to precompute: beat 0 of the incoming command while idle, the next beat while streaming.
    always_comb begin
        cmd_last_idx = (cmd_len / BPB_LEN)
                     + (((cmd_len % BPB_LEN) != '0) ? ONE_LEN : '0)
                     - ONE_LEN;
        if (state_q == IDLE) begin
            pat_seed = cmd_seed;
            pat_idx  = '0;
            pat_len  = cmd_len;
            pat_last = (cmd_last_idx == '0);
        end else begin
            pat_seed = seed_q;
            pat_idx  = beat_q + ONE_LEN;
            pat_len  = len_q;
            pat_last = (pat_idx == last_idx_q);
        end
    end

    axis_host_pkt_src_pattern_beat #(
        .DATA_BITS (DATA_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_pattern (
        .seed     (pat_seed),
        .beat_idx (pat_idx),
        .len      (pat_len),
        .is_last  (pat_last),
        .data     (pat_data),
        .keep     (pat_keep)
    );

    assign handshake = tvalid_q && m_axis.tready;

    // Next-state and next-output logic; registers hold unless a command or handshake moves them.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tid_d       = tid_q;
        seed_d      = seed_q;
        len_d       = len_q;
        last_idx_d  = last_idx_q;
        beat_d      = beat_q;
        pkt_cnt_d   = pkt_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q && (cmd_len != '0)) begin
                    state_d     = STREAM;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    seed_d      = cmd_seed;
                    len_d       = cmd_len;
                    last_idx_d  = cmd_last_idx;
                    beat_d      = '0;
                    tvalid_d    = 1'b1;
                    tdata_d     = pat_data;
                    tkeep_d     = pat_keep;
                    tlast_d     = pat_last;
                    tid_d       = cmd_id;
                end
            end
            STREAM: begin
                if (handshake) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (tlast_q) begin
                        state_d     = IDLE;
                        pkt_cnt_d   = pkt_cnt_q + 32'd1;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tdata_d     = '0;
                        tkeep_d     = '0;
                        tid_d       = '0;
                    end else begin
                        beat_d  = pat_idx;
                        tdata_d = pat_data;
                        tkeep_d = pat_keep;
                        tlast_d = pat_last;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tid_q       <= '0;
            seed_q      <= '0;
            len_q       <= '0;
            last_idx_q  <= '0;
            beat_q      <= '0;
            pkt_cnt_q   <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tid_q       <= tid_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            last_idx_q  <= last_idx_d;
            beat_q      <= beat_d;
            pkt_cnt_q   <= pkt_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign beat_cnt      = beat_cnt_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tid    = tid_q;

endmodule

// File: tb/tb_axis_host_pkt_src.sv
// Scoreboard bench for axis_host_pkt_src: commands push their expected beats
// into a queue, an independent monitor pops and compares on every handshake.
module tb_axis_host_pkt_src;

    localparam int DATA_BITS = 512;
    localparam int ID_BITS   = 6;
    localparam int LEN_BITS  = 28;
    localparam int BB        = DATA_BITS / 8;
    localparam int LANES     = DATA_BITS / 32;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic [BB-1:0]        keep;
        logic                 last;
        logic [ID_BITS-1:0]   id;
    } beat_t;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [LEN_BITS-1:0] cmd_len = '0;
    logic [ID_BITS-1:0]  cmd_id = '0;
    logic [31:0]         cmd_seed = '0;
    logic                busy;
    logic [31:0]         pkt_cnt;
    logic [31:0]         beat_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    model_pkts = 0;
    int    model_beats = 0;
    int    beats_seen = 0;
    int    tready_mode = 0;
    int    tready_phase = 0;
    bit    expect_idle_next = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;
    beat_t mon_exp;

    axis_host_pkt_src_if #(.DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS)) m_axis ();

    axis_host_pkt_src #(
        .DATA_BITS (DATA_BITS),
        .ID_BITS   (ID_BITS),
        .LEN_BITS  (LEN_BITS)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_id    (cmd_id),
        .cmd_seed  (cmd_seed),
        .m_axis    (m_axis),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .beat_cnt  (beat_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name,
                               input logic [DATA_BITS-1:0] actual,
                               input logic [DATA_BITS-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference model: a packet is ceil(len/BB) beats; lane k of beat b is seed+b*LANES+k,
    // and a beat carries min(BB, bytes still owed) valid bytes.
    task automatic pushPacket(input int unsigned len, input logic [ID_BITS-1:0] id,
                              input logic [31:0] seed);
        int unsigned nbeats;
        nbeats = (len + BB - 1) / BB;
        for (int unsigned b = 0; b < nbeats; b++) begin
            beat_t       e;
            int unsigned remaining;
            remaining = len - b * BB;
            for (int k = 0; k < LANES; k++) begin
                e.data[k*32 +: 32] = seed + 32'(b * LANES) + 32'(k);
            end
            e.keep = (remaining >= BB) ? {BB{1'b1}} : BB'((64'd1 << remaining) - 64'd1);
            e.last = (b == nbeats - 1);
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    // Issue one command; called just after a falling edge, returns just after one.
    task automatic applyStimulus(input int unsigned len, input logic [ID_BITS-1:0] id,
                                 input logic [31:0] seed);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_BITS'(len);
        cmd_id    = id;
        cmd_seed  = seed;
        while (cmd_ready !== 1'b1) begin
            @(negedge aclk);
            #1;
            w++;
            if (w > 3000) begin
                checkOutput("cmd_accept_timeout", 512'(cmd_ready), 512'(1));
                cmd_valid = 1'b0;
                return;
            end
        end
        pushPacket(len, id, seed);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge aclk);
        #1;
        checkOutput("first_beat_latency", 512'(m_axis.tvalid), 512'(len != 0));
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (!(exp_q.size() == 0 && m_axis.tvalid === 1'b0 && cmd_ready === 1'b1)) begin
            @(negedge aclk);
            #1;
            w++;
            if (w > 3000) begin
                checkOutput("drain_timeout", 512'(exp_q.size()), 512'(0));
                return;
            end
        end
    endtask

    task automatic checkCounters();
        checkOutput("pkt_cnt", 512'(pkt_cnt), 512'(32'(model_pkts)));
        checkOutput("beat_cnt", 512'(beat_cnt), 512'(32'(model_beats)));
    endtask

    // Sink ready pattern: always ready, the 1,0,0 repeating stall pattern, or random.
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            tready_phase++;
            case (tready_mode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = ((tready_phase % 3) == 0);
                default: m_axis.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each accepted beat against the scoreboard and checks stall stability.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall       = 1'b0;
            expect_idle_next = 1'b0;
        end else begin
            if (expect_idle_next) begin
                checkOutput("idle_after_last", 512'({cmd_ready, m_axis.tvalid, busy}), 512'(3'b100));
                expect_idle_next = 1'b0;
            end
            if (prev_stall) begin
                checkOutput("stall_data", m_axis.tdata, prev_beat.data);
                checkOutput("stall_ctrl", 512'({m_axis.tvalid, m_axis.tkeep, m_axis.tlast, m_axis.tid}),
                            512'({1'b1, prev_beat.keep, prev_beat.last, prev_beat.id}));
            end
            if (m_axis.tvalid && m_axis.tready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 512'(m_axis.tvalid), 512'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("beat_data", m_axis.tdata, mon_exp.data);
                    checkOutput("beat_keep", 512'(m_axis.tkeep), 512'(mon_exp.keep));
                    checkOutput("beat_last_id", 512'({m_axis.tlast, m_axis.tid}), 512'({mon_exp.last, mon_exp.id}));
                    checkOutput("busy_stream", 512'({busy, cmd_ready}), 512'(2'b10));
                    model_beats++;
                    if (mon_exp.last) begin
                        model_pkts++;
                        expect_idle_next = 1'b1;
                    end
                end
            end
            prev_stall     = m_axis.tvalid && !m_axis.tready;
            prev_beat.data = m_axis.tdata;
            prev_beat.keep = m_axis.tkeep;
            prev_beat.last = m_axis.tlast;
            prev_beat.id   = m_axis.tid;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int base;
        int unsigned len;
        int unsigned sel;

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset_ctrl", 512'({m_axis.tvalid, m_axis.tlast, cmd_ready, busy}), 512'(4'b0010));
        checkOutput("reset_data", m_axis.tdata, '0);
        checkOutput("reset_keep_id", 512'({m_axis.tkeep, m_axis.tid}), '0);
        checkOutput("reset_counters", 512'({pkt_cnt, beat_cnt}), '0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;

        $display("[TB] single 64-byte packet");
        tready_mode = 0;
        applyStimulus(64, 6'd3, 32'h0000_0100);
        waitDrain();
        checkCounters();

        $display("[TB] 130-byte packet with partial last beat");
        applyStimulus(130, 6'd5, 32'h0);
        waitDrain();
        checkCounters();

        $display("[TB] 256-byte packet with stalls");
        tready_mode = 1;
        applyStimulus(256, 6'd7, $urandom);
        waitDrain();
        checkCounters();
        tready_mode = 0;

        $display("[TB] zero-length command then 64 bytes");
        applyStimulus(0, 6'd1, 32'h1234_5678);
        applyStimulus(64, 6'd2, 32'hABCD_0000);
        waitDrain();
        checkCounters();

        $display("[TB] seed wrap");
        applyStimulus(64, 6'd4, 32'hFFFF_FFF8);
        waitDrain();
        checkCounters();

        $display("[TB] reset in the middle of a packet");
        base = beats_seen;
        applyStimulus(256, 6'd9, 32'h5555_0000);
        w = 0;
        while (beats_seen < base + 2 && w < 200) begin
            @(negedge aclk);
            w++;
        end
        checkOutput("reset_mid_reach", 512'(beats_seen - base), 512'(2));
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        checkOutput("abort_ctrl", 512'({m_axis.tvalid, m_axis.tlast, cmd_ready, busy}), 512'(4'b0010));
        checkOutput("abort_counters", 512'({pkt_cnt, beat_cnt}), '0);
        exp_q.delete();
        model_pkts  = 0;
        model_beats = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        applyStimulus(64, 6'd11, 32'h0BAD_F00D);
        waitDrain();
        checkCounters();

        $display("[TB] randomized commands");
        for (int i = 0; i < 40; i++) begin
            tready_mode = int'($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 0;
            else if (sel < 3)  len = 64 * $urandom_range(1, 4);
            else               len = $urandom_range(1, 300);
            applyStimulus(len, 6'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                waitDrain();
                checkCounters();
            end
        end
        waitDrain();
        checkCounters();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_host_pkt_src.md
Name: axis_host_pkt_src

Overview:
- AXI4SR stream transmitter: the source end of a host/card stream whose sink is a user-logic `AXI4SR.s` port, e.g. `axis_host_0_sink`.
- Converts a command (byte length, stream id, seed) into one packet of deterministic pattern beats with correct tkeep/tlast.
- Used in the config_0 shells as a traffic generator for user-logic bring-up and isolation testing, in place of the host DMA path.

Parameters:
- DATA_BITS, 512, stream data width in bits; multiple of 32.
- ID_BITS, 6, tid width.
- LEN_BITS, 28, command byte-length width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_len  in  LEN_BITS  packet length in bytes.
- cmd_id  in  ID_BITS  tid for every beat of the packet.
- cmd_seed  in  32  pattern seed.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  DATA_BITS  beat data.
- m_axis_tkeep  out  DATA_BITS/8  byte enables.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tid  out  ID_BITS  stream id.
- busy  out  1  packet in progress.
- pkt_cnt  out  32  packets fully transmitted (wraps).
- beat_cnt  out  32  beats accepted by sink (wraps).

Behaviour:
- Reset (async assert, sync release): state IDLE. cmd_ready=1. tvalid=0, tlast=0, tdata=0, tkeep=0, tid=0. busy=0. pkt_cnt=0, beat_cnt=0. All outputs are registered.
- States are IDLE and STREAM.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_len!=0: latch id and seed, compute nbeats=ceil(cmd_len/(DATA_BITS/8)), go to STREAM. First beat presents tvalid=1 on the next cycle (1-cycle latency).
  - cmd_len==0: command is consumed and dropped. No beats are sent, counters are unchanged, state stays IDLE.
- STREAM:
  - cmd_ready=0, busy=1.
  - Beat b (0-based) carries 32-bit lane k = seed + b*(DATA_BITS/32) + k, mod 2^32.
  - tkeep is all ones, except on the final beat when rem=cmd_len mod (DATA_BITS/8) is nonzero: then tkeep = low rem bits set.
  - tlast=1 only on beat nbeats-1. tid=latched id on every beat.
- AXI rules:
  - Once tvalid=1, tvalid/tdata/tkeep/tlast/tid are held stable until tready.
  - Beat advances only on tvalid&&tready; the next beat appears the following cycle with no bubble.
  - tvalid does not depend combinationally on tready.
- Packet completion: on the last-beat handshake, pkt_cnt+1, tvalid falls next cycle, state returns to IDLE. cmd_ready=1 that same following cycle, so there is one idle cycle between packets.
- beat_cnt increments on every handshake. Both counters wrap at 2^32.
- Packet of length exactly a multiple of the bus width: full tkeep on the last beat.
- Maximum cmd_len=2^LEN_BITS-1 must not overflow the beat counter; the internal counter is LEN_BITS wide.
- Reset mid-packet: immediate abort, outputs go to reset values asynchronously, partial packet is not counted. The sink must tolerate a truncated packet without tlast.
- cmd_valid while busy is ignored (cmd_ready=0); the command stays pending on the bus.

Decomposition:
- Shared package (the lynxTypes extension or a new gen_pkg) holds:
  - typedef gen_state_t {IDLE, STREAM}
  - function beat_pattern(seed, beat_idx) returning the DATA_BITS word
  - function last_keep(len) returning the keep mask
  - constant BEAT_BYTES = DATA_BITS/8
- Optional sub-module axis_pattern_beat: combinational pattern/keep generation. It is shared with a future matching checker (sink side), so verification reuses identical pattern logic.
- FSM and counters stay in the top module.

Test Plan:
- Single 64-byte cmd (len=64, id=3, seed=0x100), tready=1 -> exactly 1 beat one cycle after the cmd handshake. tlast=1, tkeep=all ones, lane0=0x100, lane15=0x10F, tid=3. pkt_cnt=1, beat_cnt=1.
- len=130, seed=0, tready=1 -> 3 beats, beat2 tkeep=0x3 (2 bytes), beat1 lane0=16, tlast only on beat2. cmd_ready returns 1 one cycle after the last handshake.
- len=256, tready toggling 1,0,0,1,... -> 4 beats. Outputs are stable during every stall and no beat is dropped or duplicated. beat_cnt=4.
- cmd_len=0 then len=64 back-to-back -> first command consumed with no tvalid. Second packet is normal; pkt_cnt=1.
- Assert aresetn=0 after beat1 of a 4-beat packet -> tvalid=0 same cycle, pkt_cnt=0, beat_cnt=0. After release, a new 64-byte command works normally.
- seed=0xFFFFFFF8, len=64 -> lane8 wraps to 0x00000000. Then pkt_cnt preset near wrap via 2^32 packets (formal or forced) -> wraps to 0.
